// File: rtl/sseg_pkg.sv
// Shared constants for the gear-indicator seven-segment scanner: glyphs,
// gear-state encodings, anode patterns and the per-digit lookup helpers.
package sseg_pkg;

  // Active-low segment glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH_T = 7'b0000111;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_N = 7'b0101011;
  localparam logic [6:0] GLYPH_R = 7'b0101111;
  localparam logic [6:0] NO_CHAR = 7'b1111111;

  typedef enum logic [1:0] {
    GEAR_IDLE    = 2'b00,
    GEAR_DRIVE   = 2'b01,
    GEAR_NEUTRAL = 2'b10,
    GEAR_REVERSE = 2'b11
  } gear_e;

  // Gear FSM state codes; they equal the mode_code that requests them.
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_DRIVE   = 2'b01;
  localparam logic [1:0] ST_NEUTRAL = 2'b10;
  localparam logic [1:0] ST_REVERSE = 2'b11;

  localparam logic [3:0] AN_0 = 4'b1110;
  localparam logic [3:0] AN_1 = 4'b1101;
  localparam logic [3:0] AN_2 = 4'b1011;
  localparam logic [3:0] AN_3 = 4'b0111;

  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    logic [3:0] an;
    case (idx)
      2'd0:    an = AN_0;
      2'd1:    an = AN_1;
      2'd2:    an = AN_2;
      default: an = AN_3;
    endcase
    return an;
  endfunction

  // Each gear owns exactly one digit position; digit 3 is always dark.
  function automatic logic [6:0] glyph_for(input logic [1:0] gear,
                                           input logic [1:0] idx);
    logic [6:0] g;
    g = NO_CHAR;
    if (idx == 2'd0 && gear == ST_REVERSE) g = GLYPH_R;
    if (idx == 2'd1 && gear == ST_NEUTRAL) g = GLYPH_N;
    if (idx == 2'd2 && gear == ST_DRIVE)   g = GLYPH_D;
    return g;
  endfunction

endpackage

// File: rtl/sseg_tick_gen.sv
// Scan-tick prescaler: counts 0..DIV-1 and pulses ce while the count is DIV-1.
module sseg_tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic ce
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Decoded from the count so that reset (count 0) forces ce low at once.
  assign ce = (cnt == LAST);

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Gear-indicator display controller: gear FSM, backtrack hold timer and a
// four-digit multiplexed scan driven by the prescaler tick.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int DIV     = 100000,
  parameter int BT_HOLD = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode_code,
  input  logic       mode_valid,
  input  logic       backtrack_req,
  output logic       ce,
  output logic [3:0] an_sel,
  output logic [6:0] char_sel,
  output logic       backtrack_active,
  output logic [1:0] mode_state
);

  localparam int HW = $clog2(BT_HOLD + 1);

  // mode_valid and backtrack_req are single-cycle strobes with no ready/ack:
  // a request is consumed on the edge it is seen, or silently dropped when
  // it is illegal or arrives while backtrack indication is held.

  logic [1:0]    state_q;
  logic [1:0]    digit_idx;
  logic [1:0]    digit_next;
  logic [HW-1:0] hold_cnt;
  logic          blocked_pair;
  logic          mode_accept;

  sseg_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce)
  );

  always_comb begin
    blocked_pair = 1'b0;
    if (state_q == ST_DRIVE && mode_code == ST_REVERSE) blocked_pair = 1'b1;
    if (state_q == ST_REVERSE && mode_code == ST_DRIVE) blocked_pair = 1'b1;
  end

  assign mode_accept = mode_valid && !backtrack_req && !backtrack_active
                       && !blocked_pair;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (mode_accept) begin
      state_q <= mode_code;
    end
  end

  assign mode_state = state_q;

  // A fresh request reloads the timer even on a tick edge, so a retrigger
  // never lets backtrack_active dip low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt         <= '0;
      backtrack_active <= 1'b0;
    end else if (backtrack_req) begin
      hold_cnt         <= HW'(BT_HOLD);
      backtrack_active <= 1'b1;
    end else if (ce && hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HW'(1);
      if (hold_cnt == HW'(1)) begin
        backtrack_active <= 1'b0;
      end
    end
  end

  assign digit_next = digit_idx + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_idx <= 2'd0;
      an_sel    <= AN_0;
      char_sel  <= NO_CHAR;
    end else if (ce) begin
      digit_idx <= digit_next;
      an_sel    <= anode_for(digit_next);
      char_sel  <= glyph_for(state_q, digit_next);
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with DIV=4, BT_HOLD=3.
module tb_sseg_scan_ctrl;

  localparam int DIV     = 4;
  localparam int BT_HOLD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode_code = 2'b00;
  logic       mode_valid = 1'b0;
  logic       backtrack_req = 1'b0;
  logic       ce;
  logic [3:0] an_sel;
  logic [6:0] char_sel;
  logic       backtrack_active;
  logic [1:0] mode_state;

  int errors = 0;
  int checks = 0;

  // Reference timeline: prescaler phase and digit index as the spec defines them.
  int m_cnt;
  int m_idx;

  sseg_scan_ctrl #(.DIV(DIV), .BT_HOLD(BT_HOLD)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mode_code        (mode_code),
    .mode_valid       (mode_valid),
    .backtrack_req    (backtrack_req),
    .ce               (ce),
    .an_sel           (an_sel),
    .char_sel         (char_sel),
    .backtrack_active (backtrack_active),
    .mode_state       (mode_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_idx <= 0;
    end else if (m_cnt == DIV - 1) begin
      m_cnt <= 0;
      m_idx <= (m_idx + 1) % 4;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  function automatic logic [3:0] exp_an(input int idx);
    case (idx)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [6:0] exp_glyph(input logic [1:0] gear, input int idx);
    if (idx == 0 && gear == 2'b11) return 7'b0101111;
    if (idx == 1 && gear == 2'b10) return 7'b0101011;
    if (idx == 2 && gear == 2'b01) return 7'b0100001;
    return 7'b1111111;
  endfunction

  // Advance to just after the next scan tick, checking ce and the new anode.
  task automatic wait_ce(input string name);
    int n;
    n = 0;
    while (m_cnt != DIV - 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL %s_tick_timeout: no tick within 20 cycles", name);
    end else if (ce !== 1'b1) begin
      errors++;
      $display("FAIL %s_ce: got %b want 1", name, ce);
    end
    @(negedge clk);
    checks++;
    if (an_sel !== exp_an(m_idx)) begin
      errors++;
      $display("FAIL %s_an_sel: got %b want %b", name, an_sel, exp_an(m_idx));
    end
  endtask

  task automatic pulse_mode(input logic [1:0] code);
    mode_code  = code;
    mode_valid = 1'b1;
    @(negedge clk);
    mode_valid = 1'b0;
  endtask

  task automatic pulse_bt();
    backtrack_req = 1'b1;
    @(negedge clk);
    backtrack_req = 1'b0;
  endtask

  task automatic check_scan(input logic [1:0] gear, input string name);
    for (int i = 0; i < 4; i++) begin
      wait_ce(name);
      checks++;
      if (char_sel !== exp_glyph(gear, m_idx)) begin
        errors++;
        $display("FAIL %s_char_sel: idx %0d got %b want %b", name, m_idx,
                 char_sel, exp_glyph(gear, m_idx));
      end
    end
  endtask

  task automatic check_state(input logic [1:0] want, input string name);
    checks++;
    if (mode_state !== want) begin
      errors++;
      $display("FAIL %s_mode_state: got %b want %b", name, mode_state, want);
    end
  endtask

  task automatic check_active(input logic want, input string name);
    checks++;
    if (backtrack_active !== want) begin
      errors++;
      $display("FAIL %s_backtrack_active: got %b want %b", name, backtrack_active, want);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (ce !== 1'b0 || an_sel !== 4'b1110 || char_sel !== 7'b1111111 ||
        backtrack_active !== 1'b0 || mode_state !== 2'b00) begin
      errors++;
      $display("FAIL %s: got ce=%b an=%b char=%b bt=%b st=%b want 0 1110 1111111 0 00",
               name, ce, an_sel, char_sel, backtrack_active, mode_state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      checks++;
      if (ce !== (k % 4 == 0)) begin
        errors++;
        $display("FAIL idle_ce: cycle %0d got %b want %b", k, ce, (k % 4 == 0));
      end
      @(negedge clk);
      checks++;
      if (an_sel !== exp_an((k / 4) % 4) || char_sel !== 7'b1111111) begin
        errors++;
        $display("FAIL idle_scan: cycle %0d got an=%b char=%b want an=%b char=1111111",
                 k, an_sel, char_sel, exp_an((k / 4) % 4));
      end
    end
  endtask

  task automatic test_drive();
    pulse_mode(2'b01);
    check_state(2'b01, "drive");
    check_scan(2'b01, "drive_scan");
  endtask

  task automatic test_gear_guard();
    pulse_mode(2'b11);
    check_state(2'b01, "d_to_r_blocked");
    pulse_mode(2'b10);
    check_state(2'b10, "d_to_n");
    check_scan(2'b10, "neutral_scan");
    pulse_mode(2'b11);
    check_state(2'b11, "n_to_r");
    check_scan(2'b11, "reverse_scan");
    pulse_mode(2'b01);
    check_state(2'b11, "r_to_d_blocked");
    pulse_mode(2'b11);
    check_state(2'b11, "r_to_r");
    pulse_mode(2'b00);
    check_state(2'b00, "r_to_idle");
  endtask

  task automatic test_backtrack();
    pulse_bt();
    check_active(1'b1, "bt_start");
    wait_ce("bt");
    check_active(1'b1, "bt_after_ce1");
    wait_ce("bt");
    check_active(1'b1, "bt_after_ce2");
    wait_ce("bt");
    check_active(1'b0, "bt_after_ce3");
  endtask

  task automatic test_retrigger();
    pulse_bt();
    check_active(1'b1, "rt_start");
    wait_ce("rt");
    wait_ce("rt");
    check_active(1'b1, "rt_before_retrigger");
    pulse_bt();
    check_active(1'b1, "rt_retrigger");
    wait_ce("rt");
    wait_ce("rt");
    check_active(1'b1, "rt_after_ce2");
    wait_ce("rt");
    check_active(1'b0, "rt_after_ce3");
  endtask

  task automatic test_mode_blocked();
    pulse_mode(2'b01);
    check_state(2'b01, "blk_setup");
    mode_code     = 2'b10;
    mode_valid    = 1'b1;
    backtrack_req = 1'b1;
    @(negedge clk);
    mode_valid    = 1'b0;
    backtrack_req = 1'b0;
    check_state(2'b01, "blk_coincide");
    check_active(1'b1, "blk_coincide");
    wait_ce("blk");
    pulse_mode(2'b10);
    check_state(2'b01, "blk_during_hold");
    check_active(1'b1, "blk_during_hold");
    wait_ce("blk");
    wait_ce("blk");
    check_active(1'b0, "blk_hold_end");
    pulse_mode(2'b10);
    check_state(2'b10, "blk_released");
  endtask

  task automatic test_reset_mid_backtrack();
    int n;
    n = 0;
    while (m_idx != 1 && n < 4) begin
      wait_ce("rst_mid_align");
      n++;
    end
    pulse_bt();
    wait_ce("rst_mid");
    check_active(1'b1, "rst_mid_pre");
    checks++;
    if (an_sel !== 4'b1011) begin
      errors++;
      $display("FAIL rst_mid_pre_an_sel: got %b want 1011", an_sel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (ce !== (k == 4)) begin
        errors++;
        $display("FAIL rst_mid_first_ce: cycle %0d got %b want %b", k, ce, (k == 4));
      end
      @(negedge clk);
    end
    checks++;
    if (an_sel !== 4'b1101 || backtrack_active !== 1'b0 || mode_state !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_after: got an=%b bt=%b st=%b want 1101 0 00",
               an_sel, backtrack_active, mode_state);
    end
  endtask

  initial begin
    test_reset();
    test_drive();
    test_gear_guard();
    test_backtrack();
    test_retrigger();
    test_mode_blocked();
    test_reset_mid_backtrack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
